// File: rtl/wall_pkg.sv
// wall_pkg: mode encodings, sweep state type and default widths for the wall field engine
package wall_pkg;
   localparam int DEF_NUM_WALLS = 18;
   localparam int DEF_COORD_W = 10;
   localparam int DEF_SPD_W = 4;
   localparam int IDX_W = 5;
   localparam logic [1:0] WM_STATIC = 2'd0;
   localparam logic [1:0] WM_HORIZ = 2'd1;
   localparam logic [1:0] WM_VERT = 2'd2;
   typedef enum logic {IDLE, SWEEP} sweep_state_e;
endpackage

// File: rtl/wall_motion_step.sv
// wall_motion_step: one bounce step of a moving coordinate between min and max
module wall_motion_step #(
   parameter int COORD_W = 10,
   parameter int SPD_W = 4
) (
   input logic [COORD_W-1:0] p,
   input logic dir,
   input logic [SPD_W-1:0] speed,
   input logic [COORD_W-1:0] min,
   input logic [COORD_W-1:0] max,
   output logic [COORD_W-1:0] p_next,
   output logic dir_next
);
   logic [COORD_W:0] up, lo_lim;
   logic frozen, hit_hi, hit_lo;
   assign up = {1'b0, p} + (COORD_W+1)'(speed);
   assign lo_lim = {1'b0, min} + (COORD_W+1)'(speed);
   assign frozen = speed == '0 || min >= max;
   assign hit_hi = up >= {1'b0, max};
   assign hit_lo = {1'b0, p} <= lo_lim;
   // the clamp checks guarantee neither the sum nor the difference leaves COORD_W bits
   assign p_next = frozen ? p :
                   !dir ? (hit_hi ? max : up[COORD_W-1:0]) :
                   (hit_lo ? min : p - COORD_W'(speed));
   assign dir_next = frozen ? dir : (dir ? !hit_lo : hit_hi);
endmodule

// File: rtl/wall_field_engine.sv
// wall_field_engine: table of static/bouncing wall rectangles with per-pixel registered hit bits
module wall_field_engine
   import wall_pkg::*;
#(
   parameter int NUM_WALLS = DEF_NUM_WALLS,
   parameter int COORD_W = DEF_COORD_W,
   parameter int SPD_W = DEF_SPD_W
) (
   input logic clk,
   input logic rst,
   input logic update,
   input logic restart,
   input logic [COORD_W-1:0] xCount,
   input logic [COORD_W-1:0] yCount,
   input logic cfg_we,
   input logic [IDX_W-1:0] cfg_idx,
   input logic [COORD_W-1:0] cfg_x,
   input logic [COORD_W-1:0] cfg_y,
   input logic [COORD_W-1:0] cfg_w,
   input logic [COORD_W-1:0] cfg_h,
   input logic [1:0] cfg_mode,
   input logic [SPD_W-1:0] cfg_speed,
   input logic [COORD_W-1:0] cfg_min,
   input logic [COORD_W-1:0] cfg_max,
   output logic [NUM_WALLS-1:0] wall,
   output logic wall_any,
   output logic busy,
   output logic overrun
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WALLS - 1);
   logic [COORD_W-1:0] start_x [NUM_WALLS];
   logic [COORD_W-1:0] start_y [NUM_WALLS];
   logic [COORD_W-1:0] cur_x [NUM_WALLS];
   logic [COORD_W-1:0] cur_y [NUM_WALLS];
   logic [COORD_W-1:0] w [NUM_WALLS];
   logic [COORD_W-1:0] h [NUM_WALLS];
   logic [COORD_W-1:0] lo [NUM_WALLS];
   logic [COORD_W-1:0] hi [NUM_WALLS];
   logic [1:0] mode [NUM_WALLS];
   logic [SPD_W-1:0] speed [NUM_WALLS];
   logic [NUM_WALLS-1:0] dir;
   sweep_state_e state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic overrun_n;
   logic [1:0] sel_mode;
   logic sel_horiz, step_en, cfg_ok, dir_n;
   logic [COORD_W-1:0] p_n;
   logic [NUM_WALLS-1:0] hit;
   assign busy = state == SWEEP;
   assign cfg_ok = cfg_idx <= LAST;
   assign sel_mode = mode[idx];
   assign sel_horiz = sel_mode == WM_HORIZ;
   assign step_en = busy && (sel_horiz || sel_mode == WM_VERT);
   wall_motion_step #(.COORD_W(COORD_W), .SPD_W(SPD_W)) u_step (
      .p(sel_horiz ? cur_x[idx] : cur_y[idx]),
      .dir(dir[idx]),
      .speed(speed[idx]),
      .min(lo[idx]),
      .max(hi[idx]),
      .p_next(p_n),
      .dir_next(dir_n)
   );
   always_comb begin
      state_n = state;
      idx_n = idx;
      overrun_n = overrun;
      if (restart) begin
         state_n = IDLE;
         idx_n = '0;
         overrun_n = 1'b0;
      end else if (state == IDLE) begin
         state_n = update ? SWEEP : IDLE;
         idx_n = '0;
      end else begin
         overrun_n = overrun | update;
         state_n = (idx == LAST) ? IDLE : SWEEP;
         idx_n = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         overrun <= overrun_n;
      end
   end
   // a same-cycle config write lands after the step/restart so it always wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WALLS; i++) begin
            start_x[i] <= '0;
            start_y[i] <= '0;
            cur_x[i] <= '0;
            cur_y[i] <= '0;
            w[i] <= '0;
            h[i] <= '0;
            lo[i] <= '0;
            hi[i] <= '0;
            mode[i] <= WM_STATIC;
            speed[i] <= '0;
         end
         dir <= '0;
      end else begin
         if (restart) begin
            for (int i = 0; i < NUM_WALLS; i++) begin
               cur_x[i] <= start_x[i];
               cur_y[i] <= start_y[i];
            end
            dir <= '0;
         end else if (step_en) begin
            if (sel_horiz) cur_x[idx] <= p_n;
            else cur_y[idx] <= p_n;
            dir[idx] <= dir_n;
         end
         if (cfg_we && cfg_ok) begin
            start_x[cfg_idx] <= cfg_x;
            start_y[cfg_idx] <= cfg_y;
            cur_x[cfg_idx] <= cfg_x;
            cur_y[cfg_idx] <= cfg_y;
            w[cfg_idx] <= cfg_w;
            h[cfg_idx] <= cfg_h;
            lo[cfg_idx] <= cfg_min;
            hi[cfg_idx] <= cfg_max;
            mode[cfg_idx] <= cfg_mode;
            speed[cfg_idx] <= cfg_speed;
            dir[cfg_idx] <= 1'b0;
         end
      end
   end
   for (genvar i = 0; i < NUM_WALLS; i++) begin : g_hit
      assign hit[i] = xCount > cur_x[i] && {1'b0, xCount} < {1'b0, cur_x[i]} + {1'b0, w[i]} &&
                      yCount > cur_y[i] && {1'b0, yCount} < {1'b0, cur_y[i]} + {1'b0, h[i]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wall <= '0;
         wall_any <= 1'b0;
      end else begin
         wall <= hit;
         wall_any <= |hit;
      end
   end
endmodule

// File: tb/tb_wall_field_engine.sv
// tb_wall_field_engine: randomized self-checking bench against a frame-level wall model
module tb_wall_field_engine;
   localparam int NW = 18;
   logic clk = 1'b0;
   logic rst, update, restart, cfg_we;
   logic [9:0] xCount, yCount, cfg_x, cfg_y, cfg_w, cfg_h, cfg_min, cfg_max;
   logic [4:0] cfg_idx;
   logic [1:0] cfg_mode;
   logic [3:0] cfg_speed;
   logic [NW-1:0] wall;
   logic wall_any, busy, overrun;
   int checks = 0;
   int errors = 0;
   int m_sx [NW], m_sy [NW], m_cx [NW], m_cy [NW], m_w [NW], m_h [NW];
   int m_mode [NW], m_spd [NW], m_mn [NW], m_mx [NW], m_dir [NW];

   wall_field_engine dut (
      .clk(clk), .rst(rst), .update(update), .restart(restart),
      .xCount(xCount), .yCount(yCount), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .cfg_mode(cfg_mode), .cfg_speed(cfg_speed), .cfg_min(cfg_min), .cfg_max(cfg_max),
      .wall(wall), .wall_any(wall_any), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int k = 0; k < NW; k++) begin
         m_sx[k] = 0; m_sy[k] = 0; m_cx[k] = 0; m_cy[k] = 0; m_w[k] = 0; m_h[k] = 0;
         m_mode[k] = 0; m_spd[k] = 0; m_mn[k] = 0; m_mx[k] = 0; m_dir[k] = 0;
      end
   endfunction

   function automatic void model_write(int k, int x, int y, int ww, int hh, int md, int s, int mn, int mx);
      if (k >= NW) return;
      m_sx[k] = x; m_sy[k] = y; m_cx[k] = x; m_cy[k] = y; m_w[k] = ww; m_h[k] = hh;
      m_mode[k] = md; m_spd[k] = s; m_mn[k] = mn; m_mx[k] = mx; m_dir[k] = 0;
   endfunction

   function automatic void model_restart();
      for (int k = 0; k < NW; k++) begin
         m_cx[k] = m_sx[k]; m_cy[k] = m_sy[k]; m_dir[k] = 0;
      end
   endfunction

   // one whole frame: every moving slot advances once
   function automatic void model_frame();
      int p, s;
      for (int k = 0; k < NW; k++) begin
         if ((m_mode[k] == 1 || m_mode[k] == 2) && m_spd[k] != 0 && m_mn[k] < m_mx[k]) begin
            p = (m_mode[k] == 1) ? m_cx[k] : m_cy[k];
            s = m_spd[k];
            if (m_dir[k] == 0) begin
               if (p + s >= m_mx[k]) begin p = m_mx[k]; m_dir[k] = 1; end
               else p = p + s;
            end else begin
               if (p <= m_mn[k] + s) begin p = m_mn[k]; m_dir[k] = 0; end
               else p = p - s;
            end
            if (m_mode[k] == 1) m_cx[k] = p;
            else m_cy[k] = p;
         end
      end
   endfunction

   function automatic logic [NW-1:0] model_hit(int x, int y);
      logic [NW-1:0] v;
      v = '0;
      for (int k = 0; k < NW; k++)
         v[k] = x > m_cx[k] && x < m_cx[k] + m_w[k] && y > m_cy[k] && y < m_cy[k] + m_h[k];
      return v;
   endfunction

   task automatic drive_cfg(int k, int x, int y, int ww, int hh, int md, int s, int mn, int mx);
      cfg_idx = 5'(k); cfg_x = 10'(x); cfg_y = 10'(y); cfg_w = 10'(ww); cfg_h = 10'(hh);
      cfg_mode = 2'(md); cfg_speed = 4'(s); cfg_min = 10'(mn); cfg_max = 10'(mx);
      cfg_we = 1'b1;
   endtask

   task automatic cfg_write(int k, int x, int y, int ww, int hh, int md, int s, int mn, int mx);
      @(negedge clk);
      drive_cfg(k, x, y, ww, hh, md, s, mn, mx);
      @(negedge clk);
      cfg_we = 1'b0;
      model_write(k, x, y, ww, hh, md, s, mn, mx);
   endtask

   task automatic wait_idle(string name, int expect_len);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (expect_len >= 0 ? n != expect_len : n >= 100) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, expect_len);
      end
   endtask

   task automatic do_update(string name);
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      model_frame();
      wait_idle(name, NW);
   endtask

   task automatic probe(string name, int x, int y);
      logic [NW-1:0] e;
      x = x < 0 ? 0 : (x > 1023 ? 1023 : x);
      y = y < 0 ? 0 : (y > 1023 ? 1023 : y);
      @(negedge clk);
      xCount = 10'(x);
      yCount = 10'(y);
      @(negedge clk);
      e = model_hit(x, y);
      checks++;
      if (wall !== e || wall_any !== |e) begin
         errors++;
         $display("FAIL %s pixel(%0d,%0d): wall=%h any=%b expected wall=%h any=%b",
                  name, x, y, wall, wall_any, e, |e);
      end
   endtask

   task automatic probe_slot(string name, int k);
      probe(name, m_cx[k] + 1, m_cy[k] + 1);
      probe(name, m_cx[k], m_cy[k] + 1);
   endtask

   task automatic check_bit(string name, logic got, logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; update = 1'b0; restart = 1'b0; xCount = '0; yCount = '0;
      drive_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cfg_we = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_bit("reset_wall_any", wall_any, 1'b0);
      check_bit("reset_wall_zero", |wall, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_overrun", overrun, 1'b0);
      rst = 1'b0;
      probe("reset_empty", 0, 0);
      probe("reset_empty", 1, 1);
   endtask

   task automatic test_static();
      cfg_write(0, 40, 46, 540, 20, 0, 0, 0, 0);
      probe("static_in", 41, 47);
      check_bit("static_wall0", wall[0], 1'b1);
      probe("static_left_edge", 40, 47);
      probe("static_right_edge", 580, 47);
      probe("static_corner", 579, 65);
   endtask

   task automatic test_horiz();
      cfg_write(1, 40, 200, 30, 10, 1, 2, 0, 490);
      probe_slot("horiz_start", 1);
      for (int i = 0; i < 300; i++) begin
         do_update("horiz");
         probe_slot("horiz", 1);
      end
   endtask

   task automatic test_vert();
      cfg_write(2, 200, 300, 10, 10, 2, 4, 0, 382);
      repeat (21) do_update("vert");
      probe("vert_clamp", 201, 383);
      check_bit("vert_at_382", wall[2], 1'b1);
      probe_slot("vert_clamp", 2);
      do_update("vert_back");
      probe("vert_378", 201, 379);
      check_bit("vert_at_378", wall[2], 1'b1);
      probe_slot("vert_back", 2);
   endtask

   task automatic test_overrun();
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      model_frame();
      repeat (4) @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      check_bit("overrun_busy", busy, 1'b1);
      wait_idle("overrun_sweep", -1);
      check_bit("overrun_set", overrun, 1'b1);
      probe_slot("overrun_single_step", 1);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      model_restart();
      check_bit("restart_overrun", overrun, 1'b0);
      check_bit("restart_busy", busy, 1'b0);
      probe_slot("restart_pos1", 1);
      probe_slot("restart_pos2", 2);
   endtask

   task automatic test_write_collision();
      cfg_write(3, 100, 600, 20, 20, 1, 5, 0, 800);
      do_update("coll_pre");
      probe_slot("coll_pre", 3);
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      repeat (3) @(negedge clk);
      drive_cfg(3, 300, 500, 50, 50, 1, 7, 10, 900);
      check_bit("coll_busy", busy, 1'b1);
      @(negedge clk);
      cfg_we = 1'b0;
      model_frame();
      model_write(3, 300, 500, 50, 50, 1, 7, 10, 900);
      wait_idle("coll_sweep", -1);
      probe_slot("coll_written", 3);
      do_update("coll_post");
      probe_slot("coll_post", 3);
   endtask

   task automatic test_restart_combo();
      do_update("combo_pre");
      @(negedge clk);
      restart = 1'b1;
      update = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      update = 1'b0;
      model_restart();
      check_bit("combo_update_dropped", busy, 1'b0);
      probe_slot("combo_restart", 1);
      do_update("combo_mid");
      @(negedge clk);
      restart = 1'b1;
      drive_cfg(4, 600, 700, 40, 40, 2, 3, 100, 900);
      @(negedge clk);
      restart = 1'b0;
      cfg_we = 1'b0;
      model_restart();
      model_write(4, 600, 700, 40, 40, 2, 3, 100, 900);
      probe_slot("combo_write", 4);
      probe_slot("combo_write_other", 1);
   endtask

   task automatic test_random();
      int op, k;
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(3));
         if (op < 2) begin
            k = int'($urandom_range(23));
            cfg_write(k, int'($urandom_range(700)), int'($urandom_range(700)),
                      int'($urandom_range(300)), int'($urandom_range(300)), int'($urandom_range(3)),
                      int'($urandom_range(15)), int'($urandom_range(500)), int'($urandom_range(1023)));
         end else if (op == 2) begin
            do_update("rand_update");
         end else begin
            @(negedge clk);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            model_restart();
         end
         probe("rand_pixel", int'($urandom_range(1023)), int'($urandom_range(1023)));
         k = int'($urandom_range(NW - 1));
         probe_slot("rand_slot", k);
      end
   endtask

   task automatic test_async_reset();
      cfg_write(0, 40, 46, 540, 20, 0, 0, 0, 0);
      probe("areset_pre", 41, 47);
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("areset_midsweep", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_bit("areset_wall", |wall, 1'b0);
      check_bit("areset_any", wall_any, 1'b0);
      check_bit("areset_busy", busy, 1'b0);
      check_bit("areset_overrun", overrun, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cfg_write(20, 0, 0, 1023, 1023, 1, 3, 0, 500);
      probe("bad_idx_empty", 500, 500);
      cfg_write(0, 40, 46, 540, 20, 0, 0, 0, 0);
      cfg_write(20, 0, 0, 1023, 1023, 1, 3, 0, 500);
      probe("bad_idx_slot0", 41, 47);
      do_update("bad_idx_update");
      probe("bad_idx_after", 500, 500);
      probe("bad_idx_after", 2, 2);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_static();
      test_horiz();
      test_vert();
      test_overrun();
      test_write_collision();
      test_restart_combo();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
